compl1_deser: RTL and testbench
===============================

COMPL1_DESER -- requirements
Module: compl1_deser

Interface
REQ-001 Parameter W, default 4, SHALL set the data width in bits (W >= 2).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous and active-high.
REQ-004 sin  input  1  SHALL carry the serial frame bit.
REQ-005 sin_valid  input  1  SHALL qualify sin; a bit is sampled only in cycles where sin_valid=1.
REQ-006 Out  output  W  SHALL present the restored (un-complemented) data word.
REQ-007 cpl  output  1  SHALL present the complement flag received in the last frame.
REQ-008 out_valid  output  1  SHALL be a one-cycle pulse marking a new Out/cpl.
REQ-009 err  output  1  SHALL flag a parity mismatch, valid with out_valid.
REQ-010 busy  output  1  SHALL be 1 while a frame is in progress (any state except IDLE).

Function
REQ-011 Frame order in sampled bits SHALL be: start (0), cpl flag, W data bits LSB first, then parity (when enabled).
REQ-012 FSM states SHALL be IDLE, FLAG, DATA, PAR, DONE.
REQ-013 IDLE: sampled sin=1 SHALL be ignored; sampled sin=0 SHALL move to FLAG.
REQ-014 FLAG: sampled bit SHALL be stored as the frame cpl flag; next state DATA with bit counter cleared.
REQ-015 DATA: each sampled bit SHALL be shifted in at index = bit counter; after bit W-1 go to PAR (parity enabled) or DONE.
REQ-016 PAR: sampled bit SHALL be compared with even parity over {flag, data}; next state DONE.
REQ-017 DONE SHALL last exactly one cycle, independent of sin_valid, then return to IDLE; a sin_valid bit in that cycle SHALL be ignored.
REQ-018 In DONE: Out SHALL load data XOR {W{flag}}, cpl SHALL load flag, out_valid=1 for that cycle.
REQ-019 err SHALL be 1 in the DONE cycle iff parity mismatched, else 0; err SHALL be 0 whenever out_valid=0.
REQ-020 Latency: out_valid SHALL assert the cycle after the last frame bit is sampled.
REQ-021 Cycles with sin_valid=0 mid-frame SHALL hold all state (gaps allowed, no timeout).
REQ-022 Out and cpl SHALL hold their value between frames, including after an errored frame.
REQ-023 Bit counter SHALL be wide enough for W and SHALL never wrap within a frame.

Reset
REQ-024 rst=1 SHALL force IDLE, Out=0, cpl=0, out_valid=0, err=0, busy=0, counter=0 on the next edge.
REQ-025 rst mid-frame SHALL abort the frame with no out_valid; rst takes priority over sampling in the same cycle.
REQ-026 The first sampled 0 after rst deasserts SHALL be treated as a start bit.

Configuration
REQ-027 Macro COMPL1_PARITY_EN defined: frame SHALL include the parity bit and PAR state per REQ-016.
REQ-028 COMPL1_PARITY_EN undefined: frame SHALL end after data bit W-1, PAR state SHALL not exist, err SHALL be tied 0.

Verification
REQ-029 W=4, parity on, frame 0,1,data 0011 (LSB first 1,1,0,0), par 1 -> Out=1100, cpl=1, out_valid 1 cycle, err=0.
REQ-030 Frame 0,0,data 1111, par 0 -> Out=1111, cpl=0, err=0; same frame with par 1 -> Out=1111, err=1.
REQ-031 Frame flag=1, data 0000 with sin_valid low for 3 cycles between each bit -> Out=1111, out_valid exactly one pulse.
REQ-032 rst pulsed after the 2nd data bit, then full frame flag=1 data 1010 -> one out_valid only, Out=0101.
REQ-033 Back-to-back frames with start bit sampled in the cycle after DONE -> two pulses, both words correct; idle 1s between frames -> no pulse.
REQ-034 Build without COMPL1_PARITY_EN, frame 0,1,0101 -> Out=1010 one cycle after last data bit, err=0.

Source files
------------

// File: rtl/compl1_deser.sv
// Serial deserializer for complement-encoded frames: start(0), cpl flag, W data bits LSB first,
// optional even parity bit (enabled by defining COMPL1_PARITY_EN); outputs the restored word.
module compl1_deser #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sin,
    input  logic         sin_valid,
    output logic [W-1:0] Out,
    output logic         cpl,
    output logic         out_valid,
    output logic         err,
    output logic         busy,
    output logic [2:0]   dbg_state
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FLAG = 3'd1,
        DATA = 3'd2,
`ifdef COMPL1_PARITY_EN
        PAR  = 3'd3,
`endif
        DONE = 3'd4
    } state_t;

    // Handshake: sin is consumed only on rising edges where sin_valid=1; out_valid is a
    // single-cycle strobe with no back-pressure, Out/cpl/err are meaningful while it is high.
    state_t         state;
    logic           flag;
    logic [W-1:0]   data;
    logic [W-1:0]   data_next;
    logic [CW-1:0]  bit_cnt;

    always_comb begin
        data_next = data;
        for (int i = 0; i < W; i++) begin
            if (bit_cnt == CW'(i)) data_next[i] = sin;
        end
    end

`ifdef COMPL1_PARITY_EN
    // Received parity bit must equal the XOR of flag and data for an even total.
    logic par_mismatch;
    assign par_mismatch = sin ^ (^{flag, data});
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            flag      <= 1'b0;
            data      <= '0;
            bit_cnt   <= '0;
            Out       <= '0;
            cpl       <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (sin_valid && !sin) state <= FLAG;
                end
                FLAG: begin
                    if (sin_valid) begin
                        flag    <= sin;
                        bit_cnt <= '0;
                        data    <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (sin_valid) begin
                        data <= data_next;
                        if (bit_cnt == CW'(W - 1)) begin
`ifdef COMPL1_PARITY_EN
                            state     <= PAR;
`else
                            state     <= DONE;
                            Out       <= data_next ^ {W{flag}};
                            cpl       <= flag;
                            out_valid <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
`ifdef COMPL1_PARITY_EN
                PAR: begin
                    if (sin_valid) begin
                        state     <= DONE;
                        Out       <= data ^ {W{flag}};
                        cpl       <= flag;
                        out_valid <= 1'b1;
                        err       <= par_mismatch;
                    end
                end
`endif
                // Any bit offered during DONE is dropped; the next start bit is taken from IDLE.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_compl1_deser.sv
// Bench for compl1_deser: directed and randomized frames checked against a word-level model;
// follows COMPL1_PARITY_EN the same way as the design.
module tb_compl1_deser;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         sin;
    logic         sin_valid;
    logic [W-1:0] Out;
    logic         cpl;
    logic         out_valid;
    logic         err;
    logic         busy;
    logic [2:0]   dbg_state;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int exp_pulses = 0;
    bit mon_en = 1'b0;
    logic [W+1:0] exp_q[$];

    compl1_deser #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_valid (sin_valid),
        .Out       (Out),
        .cpl       (cpl),
        .out_valid (out_valid),
        .err       (err),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic good_par(input logic flag, input logic [W-1:0] data);
        return logic'(($countones(data) + int'(flag)) % 2);
    endfunction

    // Expected {cpl, err, Out} of a frame, from the word-level rules.
    function automatic logic [W+1:0] model(input logic flag, input logic [W-1:0] data,
                                           input logic par);
        int   word;
        logic e;
        word = flag ? ((2 ** W) - 1 - int'(data)) : int'(data);
`ifdef COMPL1_PARITY_EN
        e = (par != good_par(flag, data));
`else
        e = 1'b0;
`endif
        return {flag, e, W'(word)};
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid === 1'b1) begin
                logic [W+1:0] e;
                pulses++;
                check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("word", 32'({cpl, err, Out}), 32'(e));
                end
            end else begin
                check("err_idle", 32'(err), 32'd0);
            end
        end
    end

    // All drivers start and end at a falling edge.
    task automatic drive_bit(input logic b);
        sin       = b;
        sin_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sin_valid = 1'b0;
        sin       = 1'($urandom_range(0, 1));
    endtask

    task automatic idle_gap(input int n);
        repeat (n) begin
            sin       = 1'($urandom_range(0, 1));
            sin_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic flag, input logic [W-1:0] data, input logic par,
                              input int gap, input logic poke_done);
        logic fb[$];
        fb.push_back(1'b0);
        fb.push_back(flag);
        for (int i = 0; i < W; i++) fb.push_back(data[i]);
`ifdef COMPL1_PARITY_EN
        fb.push_back(par);
`endif
        exp_q.push_back(model(flag, data, par));
        exp_pulses++;
        foreach (fb[k]) begin
            drive_bit(fb[k]);
            if (k != fb.size() - 1) idle_gap(gap);
        end
        check("latency", 32'(out_valid), 32'd1);
        check("busy_done", 32'(busy), 32'd1);
        sin       = 1'b0;
        sin_valid = poke_done;
        @(posedge clk);
        @(negedge clk);
        sin_valid = 1'b0;
        sin       = 1'b1;
        check("pulse_width", 32'(out_valid), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int p0;
        logic f;
        logic [W-1:0] d;
        rst       = 1'b1;
        sin       = 1'b1;
        sin_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out", 32'(Out), 32'd0);
        check("rst_cpl", 32'(cpl), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

`ifdef COMPL1_PARITY_EN
        send_frame(1'b1, 4'b0011, 1'b1, 0, 1'b0);
        check("vec29_out", 32'(Out), 32'b1100);
        check("vec29_cpl", 32'(cpl), 32'd1);
        send_frame(1'b0, 4'b1111, 1'b0, 0, 1'b0);
        check("vec30a_out", 32'(Out), 32'hF);
        send_frame(1'b0, 4'b1111, 1'b1, 1, 1'b0);
        check("vec30b_hold_out", 32'(Out), 32'hF);
`else
        send_frame(1'b1, 4'b0101, 1'b0, 0, 1'b0);
        check("vec34_out", 32'(Out), 32'b1010);
        check("vec34_cpl", 32'(cpl), 32'd1);
`endif

        p0 = pulses;
        send_frame(1'b1, 4'b0000, good_par(1'b1, 4'b0000), 3, 1'b0);
        check("gap_out", 32'(Out), 32'hF);
        check("gap_one_pulse", 32'(pulses - p0), 32'd1);

        // Abort after the second data bit; reset wins over a bit offered in the same cycle.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst       = 1'b1;
        sin       = 1'b0;
        sin_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        sin_valid = 1'b0;
        sin       = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_out", 32'(Out), 32'd0);
        p0 = pulses;
        send_frame(1'b1, 4'b1010, good_par(1'b1, 4'b1010), 0, 1'b0);
        check("after_rst_out", 32'(Out), 32'b0101);
        check("after_rst_pulses", 32'(pulses - p0), 32'd1);

        // Back-to-back frames, a bit offered during DONE, then idle ones.
        p0 = pulses;
        send_frame(1'b0, 4'b0110, good_par(1'b0, 4'b0110), 0, 1'b1);
        send_frame(1'b1, 4'b1001, good_par(1'b1, 4'b1001), 0, 1'b0);
        repeat (5) drive_bit(1'b1);
        check("idle_ones_busy", 32'(busy), 32'd0);
        check("b2b_pulses", 32'(pulses - p0), 32'd2);
        check("b2b_out", 32'(Out), 32'b0110);

        for (int n = 0; n < 24; n++) begin
            f = 1'($urandom_range(0, 1));
            d = W'($urandom_range(0, 15));
            send_frame(f, d, good_par(f, d) ^ ($urandom_range(0, 3) == 0),
                       $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) drive_bit(1'b1);
        end

        idle_gap(3);
        check("pulse_count", 32'(pulses), 32'(exp_pulses));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
